forwarding_scoreboard: RTL and testbench
========================================

# forwarding_scoreboard

Parametrised forwarding and hazard unit for the pipelined core, sitting beside the ID stage. It keeps its own shift-register scoreboard of in-flight destination registers for DEPTH post-issue stages (stage 1 = EXE … stage DEPTH = WB). From that scoreboard it produces per-source forwarding selects, load-use/no-forwarding stalls and a saturating stall-cycle counter. Unlike the previous combinational unit, it needs no dest/WB_en taps from downstream pipeline registers.

## Interface
- REG_W, 5, register address width
- NUM_SRC, 3, number of source operands checked per issue (val1, val2, store value)
- DEPTH, 3, tracked post-issue stages; stage k result feeds forwarding mux input k
- LOAD_READY, 2, first stage index at which a load's data is forwardable
- CNT_W, 16, stall counter width
- SEL_W, $clog2(DEPTH+1), derived: select width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- has_forwarding  in  1  1 = forwarding enabled; 0 = stall-only mode
- issue_valid  in  1  ID holds a valid instruction
- issue_dest  in  REG_W  destination of issuing instruction
- issue_wb_en  in  1  issuing instruction writes the register file
- issue_is_load  in  1  issuing instruction is a memory load
- src_addr  in  NUM_SRC*REG_W  source addresses, operand i at [i*REG_W +: REG_W]
- src_used  in  NUM_SRC  per-operand "actually read" flag
- flush  in  1  kill the instruction in ID (taken branch)
- stall  out  1  hold PC/IF/ID, insert bubble into EXE
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage-k result
- cnt_clear  in  1  synchronous clear of stall_count
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- Scoreboard entry[k], k=1..DEPTH: {valid, dest, is_load}. An entry is valid only if the instruction had wb_en=1 and dest≠0, so register 0 never matches.
- Each cycle all entries shift: entry[k+1] <= entry[k]. entry[DEPTH] is discarded.
- entry[1] <= issued instruction when issue_valid & ~stall & ~flush; otherwise it is loaded with a bubble (valid=0).
- Match(i,k): src_used[i] & entry[k].valid & entry[k].dest == src_addr[i].
- Forwarding mode:
  - fwd_sel[i] = lowest k with Match(i,k). The youngest producer wins; 0 if no match.
  - Hazard(i) if that youngest match has is_load and k < LOAD_READY.
  - Older matches never hide a younger unready load.
- Stall-only mode:
  - Hazard(i) if Match(i,k) for any k < DEPTH.
  - A match only at stage DEPTH gives fwd_sel=0, because the register file is write-before-read.
  - fwd_sel is always 0 in this mode.
- stall = issue_valid & ~flush & OR(Hazard). flush masks stall.
- While stalled, the ID instruction is not entered into the scoreboard, and the upstream pipeline must hold src/dest inputs stable.
- has_forwarding changes take effect combinationally in the same cycle.
- stall_count increments on each cycle with stall=1 and saturates at all-ones. If cnt_clear and stall coincide, cnt_clear wins and the counter goes to 0.

## Timing
- stall and fwd_sel are combinational from the inputs and registered scoreboard. They must be settled before the ID/EX register samples.
- Scoreboard and counter update on the rising edge of clk.
- Reset (rst=0, asynchronous, at any time including mid-stall): all entries invalid, stall_count=0.
  - With invalid entries, stall=0 and fwd_sel=0 for any input.
  - The first edge after release accepts an issue normally.
- Forwarding-mode load-use penalty is LOAD_READY-1 cycles; the defaults give 1 bubble.
- Stall-only dependent-instruction penalty is DEPTH-1 cycles from the producer's issue.
- After a flush, the next edge inserts a bubble; older in-flight entries are unaffected.

## Test plan
- ALU chain, forwarding on: issue r1←, then src0=r1 next cycle.
  - Required: fwd_sel[0]=1, stall=0.
  - One cycle later with src1=r1: fwd_sel[1]=2.
- Load-use: load r2, then src0=r2 next cycle.
  - Required: stall=1 for exactly 1 cycle, then fwd_sel[0]=2, stall=0.
  - stall_count=1.
- Stall-only mode: issue r3←, then src1=r3.
  - Required: stall=1 for 2 cycles, then fwd_sel=0.
  - Toggle has_forwarding to 1 mid-stall: stall drops in the same cycle, fwd_sel[1]=2.
- Priority and zero register:
  - r4 written at stages 1 and 3, src=r4: fwd_sel=1.
  - dest=r0 with wb_en=1, src=r0: fwd_sel=0, no stall.
  - src_used=0 on a matching operand: fwd_sel=0.
- Flush: load r5 in EXE, dependent instruction in ID with flush=1.
  - Required: stall=0, and entry[1] becomes a bubble on the next edge.
- Counter and reset:
  - Force 2^CNT_W+3 stall cycles: stall_count holds all-ones.
  - cnt_clear together with stall: stall_count=0.
  - Assert rst low mid-stall: stall=0 and all fwd_sel=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/forwarding_scoreboard_if.sv
// Issue-side bundle between the ID stage and the forwarding/hazard scoreboard.
// The ID stage is the master; the scoreboard is the slave.
interface forwarding_scoreboard_if #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
);
    logic                       has_forwarding;
    logic                       issue_valid;
    logic [REG_W-1:0]           issue_dest;
    logic                       issue_wb_en;
    logic                       issue_is_load;
    logic [NUM_SRC*REG_W-1:0]   src_addr;
    logic [NUM_SRC-1:0]         src_used;
    logic                       flush;
    logic                       stall;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       cnt_clear;
    logic [CNT_W-1:0]           stall_count;

    modport master (
        output has_forwarding, issue_valid, issue_dest, issue_wb_en, issue_is_load,
        output src_addr, src_used, flush, cnt_clear,
        input  stall, fwd_sel, stall_count
    );

    modport slave (
        input  has_forwarding, issue_valid, issue_dest, issue_wb_en, issue_is_load,
        input  src_addr, src_used, flush, cnt_clear,
        output stall, fwd_sel, stall_count
    );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Forwarding/hazard unit beside ID: a shift-register scoreboard of in-flight destinations
// drives per-operand forwarding selects, load-use stalls and a saturating stall counter.
module forwarding_scoreboard #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic                    clk,
    input logic                    rst,
    forwarding_scoreboard_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } entry_t;

    // sb_q[0] is stage 1 (EXE), sb_q[DEPTH-1] is stage DEPTH (WB).
    entry_t                   sb_q [DEPTH];
    entry_t                   issue_entry;
    logic [DEPTH-1:0]         match [NUM_SRC];
    logic [NUM_SRC-1:0]       hazard;
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stall;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    always_comb begin : match_logic
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                match[i][k] = bus.src_used[i] && sb_q[k].valid &&
                              (sb_q[k].dest == bus.src_addr[i*REG_W +: REG_W]);
            end
        end
    end

    always_comb begin : select_logic
        hazard = '0;
        sel    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.has_forwarding) begin
                // Walk oldest to youngest so the youngest producer is written last and wins.
                for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                    if (match[i][k]) begin
                        sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        hazard[i]             = sb_q[k].is_load && ((k + 1) < int'(LOAD_READY));
                    end
                end
            end else begin
                // WB stage needs no stall: the register file writes before it is read.
                for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
                    if (match[i][k]) begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = bus.issue_valid && !bus.flush && (|hazard);

    always_comb begin : issue_logic
        issue_entry = '0;
        if (bus.issue_valid && !stall && !bus.flush && bus.issue_wb_en &&
            (bus.issue_dest != '0)) begin
            issue_entry.valid   = 1'b1;
            issue_entry.dest    = bus.issue_dest;
            issue_entry.is_load = bus.issue_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : sb_reg
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q[0] <= issue_entry;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_comb begin : cnt_logic
        cnt_d = cnt_q;
        if (bus.cnt_clear) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : cnt_reg
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_sel     = sel;
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard: per-scenario stimulus tables push expected
// stall/fwd_sel into a queue, popped and compared mid-cycle against the DUT.
module tb_forwarding_scoreboard;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned LOAD_READY = 2;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned SEL_W      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    forwarding_scoreboard_if #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) bus ();

    forwarding_scoreboard #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wb;
        logic       load;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [2:0] used;
        logic       fwd_on;
        logic       flush;
        logic       exp_stall;
        logic [5:0] exp_fwd;
    } step_t;

    typedef struct packed {
        logic       stall;
        logic [5:0] fwd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic step_t mk(input logic v, input logic [4:0] d, input logic wb,
                                 input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] used,
                                 input logic fwd_on, input logic fl, input logic est,
                                 input logic [5:0] efwd);
        step_t s;
        s.valid = v; s.dest = d; s.wb = wb; s.load = ld;
        s.s0 = s0; s.s1 = s1; s.s2 = s2; s.used = used;
        s.fwd_on = fwd_on; s.flush = fl; s.exp_stall = est; s.exp_fwd = efwd;
        return s;
    endfunction

    task automatic idle();
        bus.has_forwarding = 1'b1;
        bus.issue_valid    = 1'b0;
        bus.issue_dest     = '0;
        bus.issue_wb_en    = 1'b0;
        bus.issue_is_load  = 1'b0;
        bus.src_addr       = '0;
        bus.src_used       = '0;
        bus.flush          = 1'b0;
        bus.cnt_clear      = 1'b0;
    endtask

    task automatic apply(input step_t s);
        exp_t e;
        bus.issue_valid    = s.valid;
        bus.issue_dest     = s.dest;
        bus.issue_wb_en    = s.wb;
        bus.issue_is_load  = s.load;
        bus.src_addr       = {s.s2, s.s1, s.s0};
        bus.src_used       = s.used;
        bus.has_forwarding = s.fwd_on;
        bus.flush          = s.flush;
        e.stall = s.exp_stall;
        e.fwd   = s.exp_fwd;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        bus.issue_valid = 1'b1;
        bus.src_addr    = {5'd2, 5'd1, 5'd0};
        bus.src_used    = 3'b111;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got %0b want 0", bus.stall);
        end
        checks++;
        if (bus.fwd_sel !== 6'd0) begin
            failures++; $display("FAIL reset_fwd got %b want 000000", bus.fwd_sel);
        end
        checks++;
        if (bus.stall_count !== 8'd0) begin
            failures++; $display("FAIL reset_count got %0d want 0", bus.stall_count);
        end
        bus.issue_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_chain();
        step_t seq[$];
        exp_t  e;
        do_reset();
        seq.push_back(mk(1, 5'd1, 1, 0, 5'd0, 5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd1, 5'd0, 5'd0, 3'b001, 1, 0, 0, 6'b000001));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd0, 5'd1, 5'd0, 3'b010, 1, 0, 0, 6'b001000));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd0, 5'd0, 5'd1, 3'b100, 1, 0, 0, 6'b110000));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd1, 5'd1, 5'd1, 3'b111, 1, 0, 0, 6'b000000));
        foreach (seq[j]) begin
            apply(seq[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL alu_chain step %0d stall got %0b want %0b", j, bus.stall, e.stall);
            end
            checks++;
            if (bus.fwd_sel !== e.fwd) begin
                failures++; $display("FAIL alu_chain step %0d fwd got %b want %b", j, bus.fwd_sel, e.fwd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t seq[$];
        exp_t  e;
        do_reset();
        seq.push_back(mk(1, 5'd2, 1, 1, 5'd0, 5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd8, 1, 0, 5'd2, 5'd0, 5'd0, 3'b001, 1, 0, 1, 6'b000001));
        seq.push_back(mk(1, 5'd8, 1, 0, 5'd2, 5'd0, 5'd0, 3'b001, 1, 0, 0, 6'b000010));
        seq.push_back(mk(0, 5'd0, 0, 0, 5'd8, 5'd0, 5'd0, 3'b001, 1, 0, 0, 6'b000001));
        foreach (seq[j]) begin
            apply(seq[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL load_use step %0d stall got %0b want %0b", j, bus.stall, e.stall);
            end
            checks++;
            if (bus.fwd_sel !== e.fwd) begin
                failures++; $display("FAIL load_use step %0d fwd got %b want %b", j, bus.fwd_sel, e.fwd);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_count !== 8'd1) begin
            failures++; $display("FAIL load_use_count got %0d want 1", bus.stall_count);
        end
    endtask

    task automatic test_stall_only();
        step_t seq[$];
        exp_t  e;
        do_reset();
        seq.push_back(mk(1, 5'd3, 1, 0, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd9, 1, 0, 5'd0, 5'd3, 5'd0, 3'b010, 0, 0, 1, 6'b000000));
        seq.push_back(mk(1, 5'd9, 1, 0, 5'd0, 5'd3, 5'd0, 3'b010, 0, 0, 1, 6'b000000));
        seq.push_back(mk(1, 5'd9, 1, 0, 5'd0, 5'd3, 5'd0, 3'b010, 0, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd0, 5'd9, 5'd0, 3'b010, 0, 0, 1, 6'b000000));
        seq.push_back(mk(1, 5'd0, 0, 0, 5'd0, 5'd9, 5'd0, 3'b010, 1, 0, 0, 6'b001000));
        foreach (seq[j]) begin
            apply(seq[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL stall_only step %0d stall got %0b want %0b", j, bus.stall, e.stall);
            end
            checks++;
            if (bus.fwd_sel !== e.fwd) begin
                failures++; $display("FAIL stall_only step %0d fwd got %b want %b", j, bus.fwd_sel, e.fwd);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_count !== 8'd3) begin
            failures++; $display("FAIL stall_only_count got %0d want 3", bus.stall_count);
        end
    endtask

    task automatic test_priority_zero();
        step_t seq[$];
        exp_t  e;
        do_reset();
        seq.push_back(mk(1, 5'd4,  1, 0, 5'd0, 5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd11, 1, 0, 5'd0, 5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd4,  1, 0, 5'd0, 5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd0,  1, 0, 5'd4, 5'd0, 5'd0, 3'b001, 1, 0, 0, 6'b000001));
        seq.push_back(mk(0, 5'd0,  0, 0, 5'd0, 5'd4, 5'd4, 3'b011, 1, 0, 0, 6'b001000));
        seq.push_back(mk(1, 5'd0,  0, 0, 5'd0, 5'd0, 5'd0, 3'b111, 0, 0, 0, 6'b000000));
        foreach (seq[j]) begin
            apply(seq[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL priority step %0d stall got %0b want %0b", j, bus.stall, e.stall);
            end
            checks++;
            if (bus.fwd_sel !== e.fwd) begin
                failures++; $display("FAIL priority step %0d fwd got %b want %b", j, bus.fwd_sel, e.fwd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        step_t seq[$];
        exp_t  e;
        do_reset();
        seq.push_back(mk(1, 5'd5,  1, 1, 5'd0,  5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd12, 1, 0, 5'd5,  5'd0, 5'd0, 3'b001, 1, 1, 0, 6'b000001));
        seq.push_back(mk(1, 5'd13, 1, 0, 5'd12, 5'd5, 5'd0, 3'b011, 1, 0, 0, 6'b001000));
        seq.push_back(mk(1, 5'd13, 1, 1, 5'd0,  5'd0, 5'd0, 3'b000, 1, 0, 0, 6'b000000));
        seq.push_back(mk(1, 5'd0,  0, 0, 5'd13, 5'd0, 5'd0, 3'b001, 1, 0, 1, 6'b000001));
        seq.push_back(mk(1, 5'd0,  0, 0, 5'd13, 5'd0, 5'd0, 3'b001, 1, 0, 0, 6'b000010));
        foreach (seq[j]) begin
            apply(seq[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL flush step %0d stall got %0b want %0b", j, bus.stall, e.stall);
            end
            checks++;
            if (bus.fwd_sel !== e.fwd) begin
                failures++; $display("FAIL flush step %0d fwd got %b want %b", j, bus.fwd_sel, e.fwd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_counter();
        exp_t e;
        int   stalls    = 0;
        int   model_cnt = 0;
        int   i         = 0;
        int   target    = (1 << CNT_W) + 3;
        int   cnt_max   = (1 << CNT_W) - 1;
        do_reset();
        // Self-dependent instruction in stall-only mode: issue, stall, stall, issue, ...
        bus.has_forwarding = 1'b0;
        bus.issue_valid    = 1'b1;
        bus.issue_dest     = 5'd3;
        bus.issue_wb_en    = 1'b1;
        bus.src_addr       = {5'd0, 5'd0, 5'd3};
        bus.src_used       = 3'b001;
        while (stalls < target) begin
            e.stall = ((i % 3) != 0);
            e.fwd   = '0;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                failures++; $display("FAIL counter cycle %0d stall got %0b want %0b", i, bus.stall, e.stall);
            end
            if (e.stall) begin
                stalls++;
                if (model_cnt < cnt_max) model_cnt++;
            end
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (bus.stall_count !== CNT_W'(model_cnt)) begin
            failures++; $display("FAIL counter_saturate got %0d want %0d", bus.stall_count, model_cnt);
        end
        if ((i % 3) == 0) begin
            @(posedge clk); #1;
            i++;
        end
        bus.cnt_clear = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++; $display("FAIL clear_stall got %0b want 1", bus.stall);
        end
        @(posedge clk); #1;
        bus.cnt_clear = 1'b0;
        checks++;
        if (bus.stall_count !== 8'd0) begin
            failures++; $display("FAIL clear_count got %0d want 0", bus.stall_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Stall-only hazard lasting two cycles, reset during the second one.
        bus.has_forwarding = 1'b0;
        bus.issue_valid    = 1'b1;
        bus.issue_dest     = 5'd3;
        bus.issue_wb_en    = 1'b1;
        @(posedge clk); #1;
        bus.issue_dest = 5'd9;
        bus.src_addr   = {5'd0, 5'd0, 5'd3};
        bus.src_used   = 3'b001;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.stall_count !== 8'd1) begin
            failures++; $display("FAIL pre_reset stall=%0b count=%0d want 1/1", bus.stall, bus.stall_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL async_stall got %0b want 0", bus.stall);
        end
        checks++;
        if (bus.stall_count !== 8'd0) begin
            failures++; $display("FAIL async_count got %0d want 0", bus.stall_count);
        end
        @(negedge clk);
        rst = 1'b1;
        // Forwarding-mode load-use stall with a nonzero select, then reset.
        idle();
        bus.issue_valid   = 1'b1;
        bus.issue_dest    = 5'd2;
        bus.issue_wb_en   = 1'b1;
        bus.issue_is_load = 1'b1;
        @(posedge clk); #1;
        bus.issue_dest    = 5'd8;
        bus.issue_is_load = 1'b0;
        bus.src_addr      = {5'd0, 5'd0, 5'd2};
        bus.src_used      = 3'b001;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.fwd_sel !== 6'b000001) begin
            failures++; $display("FAIL pre_reset_fwd stall=%0b fwd=%b want 1/000001", bus.stall, bus.fwd_sel);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.fwd_sel !== 6'd0) begin
            failures++; $display("FAIL async_fwd stall=%0b fwd=%b want 0/000000", bus.stall, bus.fwd_sel);
        end
        // First edge after release accepts an issue.
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd1;
        bus.issue_wb_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle();
        bus.src_addr = {5'd0, 5'd0, 5'd1};
        bus.src_used = 3'b001;
        @(negedge clk);
        checks++;
        if (bus.fwd_sel !== 6'b000001) begin
            failures++; $display("FAIL post_reset_issue fwd got %b want 000001", bus.fwd_sel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1 rst = 1'b0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_stall_only();
        test_priority_zero();
        test_flush();
        test_counter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
